reorder_buffer_commit: RTL

//  In-order completion stage downstream of the CDB arbiter. Dispatch allocates one entry
//  per issued instruction (destination reg + reservation-station tag). CDB broadcasts mark

---
 rtl/tomasulo_pkg.sv | 21 ++
 rtl/rob_tag_match.sv | 43 ++++
 rtl/reorder_buffer_commit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tomasulo_pkg
// Brief    : Shared tags, sentinel value and default widths for the Tomasulo core.
// Revision : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

  localparam int TAG_W_DEF  = 4;
  localparam int REG_W_DEF  = 3;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0]  FREE_REGISTER    = 4'd0;
  localparam logic [3:0]  RES_STATION_ADD1 = 4'd1;
  localparam logic [3:0]  RES_STATION_ADD2 = 4'd2;

  // Marks a register value that has not been produced yet.
  localparam logic [15:0] SEM_VALOR        = 16'hFFF0;

endpackage
`default_nettype wire

// File: rtl/rob_tag_match.sv
`default_nettype none
// ============================================================================
// Module   : rob_tag_match
// Brief    : Finds the oldest pending ROB entry waiting on a CDB tag.
// Revision : 1.0 - initial release
// ============================================================================
module rob_tag_match
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_done,
  input  logic [TAG_W-1:0] i_tag [DEPTH],
  input  logic [IDX_W-1:0] i_head,
  input  logic [TAG_W-1:0] i_cdb_tag,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [TAG_W-1:0] c_free_tag = TAG_W'(FREE_REGISTER);

  logic [IDX_W-1:0] w_pos;

  // Scan youngest-to-oldest so the last hit written is the oldest one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = i_head;
    w_pos = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_pos = i_head + IDX_W'(k);
      if (i_valid[w_pos] && !i_done[w_pos] && (i_tag[w_pos] == i_cdb_tag) &&
          (i_cdb_tag != c_free_tag)) begin
        o_hit = 1'b1;
        o_idx = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer_commit.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_commit
// Brief    : In-order ROB: allocate at dispatch, complete from CDB, retire one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_commit
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Alloc_valid,
  input  logic [TAG_W-1:0]  Alloc_tag,
  input  logic [REG_W-1:0]  Alloc_reg,
  output logic              Alloc_ready,
  output logic [IDX_W-1:0]  Alloc_idx,
  input  logic              Cdb_valid,
  input  logic [TAG_W-1:0]  Cdb_tag,
  input  logic [DATA_W-1:0] Cdb_data,
  output logic              Commit_valid,
  output logic [REG_W-1:0]  Commit_reg,
  output logic [DATA_W-1:0] Commit_data,
  output logic [IDX_W:0]    Count,
  output logic              Empty,
  output logic              Full
);

  localparam int                CNT_W       = IDX_W + 1;
  localparam logic [DATA_W-1:0] c_sem_valor = DATA_W'(SEM_VALOR);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [REG_W-1:0]  r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_commit_valid;
  logic [REG_W-1:0]  r_commit_reg;
  logic [DATA_W-1:0] r_commit_data;

  logic              w_hit;
  logic [IDX_W-1:0]  w_match_idx;
  logic              w_alloc;
  logic              w_commit;
  logic              w_cdb;

  rob_tag_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_match (
    .i_valid   (r_valid),
    .i_done    (r_done),
    .i_tag     (r_tag),
    .i_head    (r_head),
    .i_cdb_tag (Cdb_tag),
    .o_hit     (w_hit),
    .o_idx     (w_match_idx)
  );

  assign Full         = (r_count == CNT_W'(DEPTH));
  assign Empty        = (r_count == '0);
  assign Alloc_ready  = !Full;
  assign Alloc_idx    = r_tail;
  assign Count        = r_count;
  assign Commit_valid = r_commit_valid;
  assign Commit_reg   = r_commit_reg;
  assign Commit_data  = r_commit_data;

  // Matched entries are never done, so they can't collide with head (commit) or tail (alloc).
  assign w_alloc  = Alloc_valid && !Full;
  assign w_commit = r_valid[r_head] && r_done[r_head];
  assign w_cdb    = Cdb_valid && w_hit;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_valid        <= '0;
      r_done         <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_reg   <= '0;
      r_commit_data  <= c_sem_valor;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_reg[i]  <= '0;
        r_data[i] <= c_sem_valor;
      end
    end else if (Flush) begin
      r_valid        <= '0;
      r_done         <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_commit) begin
        r_commit_reg    <= r_reg[r_head];
        r_commit_data   <= r_data[r_head];
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_data[r_head]  <= c_sem_valor;
        r_head          <= r_head + 1'b1;
      end
      if (w_cdb) begin
        r_done[w_match_idx] <= 1'b1;
        r_data[w_match_idx] <= Cdb_data;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tag[r_tail]   <= Alloc_tag;
        r_reg[r_tail]   <= Alloc_reg;
        r_data[r_tail]  <= c_sem_valor;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
